// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side streaming stage: FIFO geometry,
// packet framing defaults and the stream beat type.
package fifo_rd_stream_pkg;

    localparam int FIFO_WIDTH      = 16;
    localparam int FIFO_DEPTH      = 16;
    localparam int PKT_LEN_DEFAULT = 4;

    localparam int BEAT_CNT_W = 8;
    localparam int OCC_W      = 2;

    typedef logic [OCC_W-1:0]      occ_t;
    typedef logic [BEAT_CNT_W-1:0] beat_t;

    typedef struct packed {
        logic [FIFO_WIDTH-1:0] data;
        logic                  last;
    } stream_beat_t;

endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry output buffer: entry 0 drives the stream, entry 1 absorbs the
// word that was already in flight when the consumer stalled.
module stream_skid_buf2
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_i,
    input  logic [WIDTH-1:0] cap_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output occ_t             occ_o,
    output occ_t             occ_nxt_o
);

    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    occ_t             occ_q, occ_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({pop_i, cap_i})
            2'b01: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    ent0_d = cap_data_i;
                end else begin
                    ent1_d = cap_data_i;
                end
            end
            2'b10: begin
                occ_d  = occ_q - 2'd1;
                ent0_d = ent1_q;
            end
            2'b11: begin
                // Capture lands in whichever slot the shift frees; occupancy holds.
                if (occ_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = cap_data_i;
                end else begin
                    ent0_d = cap_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign valid_o   = (occ_q != 2'd0);
    assign data_o    = ent0_q;
    assign occ_o     = occ_q;
    assign occ_nxt_o = occ_d;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO drain stage: issues reads, hides the FIFO's registered read latency
// behind a 2-entry buffer and frames the output into fixed-length packets.
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = fifo_rd_stream_pkg::FIFO_WIDTH,
    parameter int PKT_LEN    = fifo_rd_stream_pkg::PKT_LEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [7:0]            pkt_count
);
    import fifo_rd_stream_pkg::*;

    localparam beat_t LAST_BEAT = beat_t'(PKT_LEN - 1);

    logic       inflight_q, inflight_d;
    beat_t      beat_q, beat_d;
    logic [7:0] pkt_q, pkt_d;
    logic       last_q, last_d;
    occ_t       occ, occ_nxt;
    logic       pop;
    logic [2:0] load;

    stream_skid_buf2 #(
        .WIDTH(FIFO_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_i     (inflight_q),
        .cap_data_i(fifo_data_out),
        .pop_i     (pop),
        .valid_o   (m_valid),
        .data_o    (m_data),
        .occ_o     (occ),
        .occ_nxt_o (occ_nxt)
    );

    always_comb begin
        pop  = m_valid && m_ready;
        // Words held plus words promised, after this cycle's pop leaves.
        load = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = rst_n && enable && !fifo_empty && (load < 3'd2);
        inflight_d = fifo_rd_en;

        beat_d = beat_q;
        pkt_d  = pkt_q;
        if (pop) begin
            if (last_q) begin
                beat_d = '0;
                pkt_d  = pkt_q + 8'd1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
        // Registered last marker tracks whatever word entry 0 will hold next.
        last_d = (occ_nxt != 2'd0) && (beat_d == LAST_BEAT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            beat_q     <= '0;
            pkt_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            pkt_q      <= pkt_d;
            last_q     <= last_d;
        end
    end

    assign m_last    = last_q;
    assign pkt_count = pkt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream with a behavioural FIFO and a
// scoreboard of expected output beats.
module tb_fifo_rd_stream;
    import fifo_rd_stream_pkg::*;

    localparam int W  = 16;
    localparam int PL = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         m_ready = 1'b0;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_last;
    logic [W-1:0] fifo_data_out = '0;
    logic [W-1:0] m_data;
    logic [7:0]   pkt_count;

    logic [W-1:0] mem [0:1023];
    int           wr_cnt = 0;
    int           rd_cnt = 0;

    int           checks = 0;
    int           failures = 0;
    stream_beat_t sb [$];
    int           push_idx = 0;
    int           out_cnt = 0;
    int           exp_pkt = 0;

    bit           have_prev = 1'b0;
    logic         prev_valid, prev_ready, prev_last;
    logic [W-1:0] prev_data;

    int           r0, o0;

    fifo_rd_stream #(
        .FIFO_WIDTH(W),
        .PKT_LEN   (PL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_cnt == rd_cnt);

    // Registered-read FIFO: data appears the cycle after an accepted read.
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data_out <= mem[rd_cnt % 1024];
            rd_cnt        <= rd_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        stream_beat_t e;
        mem[wr_cnt % 1024] = w;
        wr_cnt++;
        e.data = w;
        e.last = ((push_idx % PL) == (PL - 1));
        sb.push_back(e);
        push_idx++;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (sb.size() != 0 || m_valid); i++) @(negedge clk);
        @(negedge clk);
        check_eq("drain_sb_empty", sb.size(), 0);
        check_eq("drain_m_valid", m_valid, 0);
    endtask

    // Stream monitor: invariants, hold-stability and scoreboard comparison.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_pkt   = 0;
            have_prev = 1'b0;
        end else begin
            check_eq("rd_en_when_empty", fifo_rd_en & fifo_empty, 0);
            check_eq("occ_plus_inflight_le2", (dut.occ + dut.inflight_q) <= 2, 1);
            if (have_prev && prev_valid && !prev_ready) begin
                check_eq("hold_valid", m_valid, 1);
                check_eq("hold_data", m_data, prev_data);
                check_eq("hold_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_word", sb.size(), 1);
                end else begin
                    stream_beat_t e;
                    e = sb.pop_front();
                    check_eq("out_data", m_data, e.data);
                    check_eq("out_last", m_last, e.last);
                    out_cnt++;
                    if (e.last) exp_pkt++;
                end
            end
            have_prev  = 1'b1;
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_pkt_count", pkt_count, 0);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("idle_rd_en", fifo_rd_en, 0);
            check_eq("idle_m_valid", m_valid, 0);
            check_eq("idle_pkt_count", pkt_count, 0);
        end

        // Streaming with latency check
        @(posedge clk); #1;
        enable  = 1'b0;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(W'(i));
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        check_eq("stream_first_rd", fifo_rd_en, 1);
        check_eq("stream_lat0_valid", m_valid, 0);
        @(negedge clk);
        check_eq("stream_lat1_valid", m_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("stream_back_to_back", m_valid, 1);
        end
        @(negedge clk);
        check_eq("stream_done_valid", m_valid, 0);
        check_eq("stream_pkt_count", pkt_count, 2);

        // Backpressure
        @(posedge clk); #1;
        m_ready = 1'b0;
        r0 = rd_cnt;
        for (int i = 1; i <= 8; i++) push(W'(16'h0100 + i));
        repeat (10) @(negedge clk);
        check_eq("bp_reads_issued", rd_cnt - r0, 2);
        check_eq("bp_valid", m_valid, 1);
        check_eq("bp_data", m_data, 16'h0101);
        @(posedge clk); #1 m_ready = 1'b1;
        drain();
        check_eq("bp_pkt_count", pkt_count, exp_pkt);

        // Random stall with random FIFO fill
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk); #1;
                    push(W'(16'h1000 + i));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                repeat (250) begin
                    @(posedge clk); #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk); #1 m_ready = 1'b1;
        drain();
        check_eq("rand_pkt_count", pkt_count, exp_pkt);

        // Mid-operation reset
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(W'(16'h0200 + i));
        repeat (5) @(negedge clk);
        check_eq("mr_occ_full", dut.occ, 2);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check_eq("mr_m_valid", m_valid, 0);
        check_eq("mr_m_data", m_data, 0);
        check_eq("mr_m_last", m_last, 0);
        check_eq("mr_pkt_count", pkt_count, 0);
        check_eq("mr_rd_en", fifo_rd_en, 0);
        wr_cnt   = rd_cnt;
        push_idx = 0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 1; i <= 6; i++) push(W'(16'h0B00 + i));
        drain();
        check_eq("mr_pkt_after", pkt_count, 1);

        // Enable gating with one read in flight
        @(posedge clk); #1 push(16'h0C01);
        @(posedge clk); #1;
        enable = 1'b0;
        r0 = rd_cnt;
        o0 = out_cnt;
        check_eq("gate_inflight", dut.inflight_q, 1);
        for (int i = 2; i <= 5; i++) push(W'(16'h0C00 + i));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("gate_rd_en", fifo_rd_en, 0);
        end
        check_eq("gate_no_reads", rd_cnt - r0, 0);
        check_eq("gate_inflight_emitted", out_cnt - o0, 1);
        @(posedge clk); #1 enable = 1'b1;
        drain();
        check_eq("gate_pkt_count", pkt_count, exp_pkt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
